// File: rtl/pfa_digit_serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle, LSD first, with group propagate/generate accumulation.
// Optional macro PFA_SUB_EN adds a 'sub' port for two's-complement subtraction.
module pfa_digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef PFA_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             p_grp,
  output logic             g_grp
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_p;
  logic             r_g;
  logic [KW-1:0]    r_k;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic [DIGIT-1:0] w_ad;
  logic [DIGIT-1:0] w_bd;
  logic [DIGIT:0]   w_full;
  logic             w_dp;
  logic             w_dg;

`ifdef PFA_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign w_accept = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last   = (r_k == KW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operands are shifted down so the current digit always sits in the low bits.
  always_comb begin
    w_ad   = r_a[DIGIT-1:0];
    w_bd   = r_b[DIGIT-1:0];
    w_full = {1'b0, w_ad} + {1'b0, w_bd} + {{DIGIT{1'b0}}, r_carry};
    w_dp   = 1'b1;
    w_dg   = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      w_dg = (w_ad[i] & w_bd[i]) | ((w_ad[i] | w_bd[i]) & w_dg);
      w_dp = w_dp & (w_ad[i] | w_bd[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_p     <= 1'b0;
      r_g     <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_sum   <= '0;
      r_carry <= w_c_in;
      r_p     <= 1'b1;
      r_g     <= 1'b0;
      r_k     <= '0;
    end else if (r_state == StRun) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      // New digit enters at the top; after N shifts digit 0 lands at bit 0.
      r_sum   <= (r_sum >> DIGIT) | (WIDTH'(w_full[DIGIT-1:0]) << (WIDTH - DIGIT));
      r_carry <= w_full[DIGIT];
      r_p     <= r_p & w_dp;
      r_g     <= w_dg | (w_dp & r_g);
      r_k     <= r_k + KW'(1);
    end
  end

  assign busy  = (r_state == StRun);
  assign done  = (r_state == StDone);
  assign sum   = r_sum;
  assign cout  = r_carry;
  assign p_grp = r_p;
  assign g_grp = r_g;

endmodule

// File: tb/tb_pfa_digit_serial_adder.sv
// Self-checking bench for pfa_digit_serial_adder: directed and random operations vs. an arithmetic model.
module tb_pfa_digit_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             p_grp;
  logic             g_grp;
`ifdef PFA_SUB_EN
  logic             sub;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [WIDTH-1:0] e_a;
  logic [WIDTH-1:0] e_b;
  logic             e_c;
  logic             e_sub;
  logic [WIDTH-1:0] e_sum;

  always #5 clk = ~clk;

  pfa_digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef PFA_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .p_grp (p_grp),
    .g_grp (g_grp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse at a negedge; returns at the first RUN negedge.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                        input logic tc, input logic ts);
    a     = ta;
    b     = tb2;
    cin   = tc;
`ifdef PFA_SUB_EN
    sub   = ts;
`endif
    e_a   = ta;
    e_b   = tb2;
    e_c   = tc;
    e_sub = ts;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, optionally scrambling inputs during RUN, then check the result.
  task automatic finish_op(input string tag, input bit noise);
    int               nb  = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] bb;
    logic             c;
    logic [WIDTH:0]   full;
    logic [WIDTH:0]   gen_sum;
    logic             prop;
    while (done !== 1'b1 && cyc < int'(4 * N + 8)) begin
      if (busy === 1'b1) nb++;
      if (noise) begin
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    bb      = e_sub ? ~e_b : e_b;
    c       = e_sub ? 1'b1 : e_c;
    full    = {1'b0, e_a} + {1'b0, bb} + (WIDTH + 1)'(c);
    gen_sum = {1'b0, e_a} + {1'b0, bb};
    prop    = &(e_a | bb);
    e_sum   = full[WIDTH-1:0];
    check({tag, "_busy_cycles"}, nb, N);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, full[WIDTH-1:0]);
    check({tag, "_cout"}, cout, full[WIDTH]);
    check({tag, "_p_grp"}, p_grp, prop);
    check({tag, "_g_grp"}, g_grp, gen_sum[WIDTH]);
    check({tag, "_inv"}, cout, g_grp | (p_grp & c));
  endtask

  // One cycle after done: pulse gone, result held.
  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_held_sum"}, sum, e_sum);
  endtask

  initial begin
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef PFA_SUB_EN
    sub   = 1'b0;
`endif
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_p", p_grp, 0);
    check("rst_g", g_grp, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    finish_op("dir_00ff", 0);
    check_idle("dir_00ff");
    launch(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    finish_op("dir_ffff", 0);
    check_idle("dir_ffff");
    launch(16'h8000, 16'h8000, 1'b0, 1'b0);
    finish_op("dir_8000", 0);
    check_idle("dir_8000");

    launch(16'h1234, 16'h4321, 1'b1, 1'b0);
    finish_op("noise", 1);
    check_idle("noise");

    // Back-to-back: start held at the DONE edge must go straight into RUN.
    launch(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    finish_op("b2b_first", 0);
    launch(16'h0F0F, 16'hF0F1, 1'b1, 1'b0);
    check("b2b_busy", busy, 1);
    finish_op("b2b_second", 0);
    check_idle("b2b_second");

    // Reset after edge 2 of RUN.
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_p", p_grp, 0);
    check("midrst_g", g_grp, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(N) + 2; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("midrst_no_activity", seen, 0);
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    finish_op("after_rst", 0);
    check_idle("after_rst");

    for (int i = 0; i < 12; i++) begin
      launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
      finish_op($sformatf("rnd%0d", i), 1'($urandom));
      check_idle($sformatf("rnd%0d", i));
    end

`ifdef PFA_SUB_EN
    launch(16'h0005, 16'h0007, 1'b0, 1'b1);
    finish_op("sub_5m7", 0);
    check("sub_5m7_lit_sum", sum, 32'hFFFE);
    check("sub_5m7_lit_cout", cout, 0);
    check_idle("sub_5m7");
    launch(16'h0007, 16'h0005, 1'b1, 1'b1);
    finish_op("sub_7m5", 0);
    check("sub_7m5_lit_sum", sum, 32'h0002);
    check("sub_7m5_lit_cout", cout, 1);
    check_idle("sub_7m5");
    for (int i = 0; i < 6; i++) begin
      launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      finish_op($sformatf("subrnd%0d", i), 0);
      check_idle($sformatf("subrnd%0d", i));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pfa_digit_serial_adder.md
Name: pfa_digit_serial_adder

Overview:
- Digit-serial successor to the single-bit partial full adder (sum, propagate, generate).
- Adds two WIDTH-bit operands DIGIT bits per clock, least significant digit first.
- Accumulates the group propagate/generate terms across the whole word, for a ripple-free carry check at the next level.
- Sits between switch/register operand sources and result registers/LEDs; start/done handshake.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- (derived) N = WIDTH/DIGIT digit cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in; latched on accepted start.
- busy  output  1  high while digits are being processed (RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  carry out of bit WIDTH-1.
- p_grp  output  1  group propagate: AND over all bits of (a_i OR b_i).
- g_grp  output  1  group generate: lookahead combine of the (a_i AND b_i) terms, LSB to MSB.

Behaviour:
- Reset (async, any state): state IDLE; busy, done, sum, cout, p_grp and g_grp all 0; digit counter 0; operand registers 0.
- States are IDLE, RUN and DONE.
- IDLE: on start=1 at an edge:
  - latch a, b and cin;
  - clear sum;
  - set the internal carry to cin;
  - set the group accumulators to P=1, G=0;
  - set counter k=0;
  - go to RUN.
- RUN: busy=1. Each edge processes digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1):
  - sum digit = (a_d + b_d + carry) mod 2^DIGIT;
  - carry = bit DIGIT of (a_d + b_d + carry);
  - digit p = AND of (a_i|b_i);
  - digit g = combine of (a_i&b_i) within the digit;
  - G <= g | (p & G);
  - P <= P & p;
  - k increments.
  - After the edge that processes k=N-1, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - cout = final carry; p_grp/g_grp = final P/G.
  - Next edge: start=1 is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge N. For the defaults (N=4) that is after edge 4. Throughput is one result per N+1 cycles.
- start while in RUN is ignored; a, b and cin may change freely in RUN without effect.
- sum/cout/p_grp/g_grp change only at the digit edges of an accepted operation, and are stable from DONE until the next accepted start.
- sum/cout are not valid during RUN; partial values are visible but undefined for checking.
- Invariant in DONE: cout == g_grp | (p_grp & cin_latched).
- Invariant in DONE: {cout,sum} == a + b + cin, computed at WIDTH+1 bits.
- Reset asserted mid-RUN aborts the operation; no done pulse is produced; outputs read 0.
- DIGIT == WIDTH is legal: N=1, single RUN cycle.

Optional Feature:
- Macro: PFA_SUB_EN.
- Defined: adds port sub (input, 1), latched on accepted start.
  - When the latched sub=1: b_latched = ~b, and the internal carry starts at 1 (the cin port is ignored).
  - cout=1 means no borrow; p_grp/g_grp are computed on the inverted b.
  - When sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=16/DIGIT=4: a=0x00FF, b=0x0001, cin=0, start pulse -> busy for 4 cycles, done after edge 4, sum=0x0100, cout=0, p_grp=0, g_grp=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, p_grp=1, g_grp=0; invariant holds.
- a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, g_grp=1, p_grp=0.
- start re-pulsed with new operands during RUN -> ignored; result is from the first operands. start held high in DONE -> a new operation begins with no IDLE cycle.
- rst asserted after edge 2 of RUN -> all outputs 0 immediately, state IDLE, no done; the next start completes normally.
- PFA_SUB_EN defined, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Same with a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
